apb_ram_slave: RTL and testbench

APB4 slave front end for the dual-port word RAM. Accepts APB transfers from the bus, decodes and checks the byte address, and drives the RAM write port (A) and read port (B). Read data returns from the RAM's registered, read-gated output. Sits directly upstream of the RAM, between the APB interconnect and the RAM instance.

---
 rtl/apb_ram_pkg.sv | 15 +
 rtl/apb_ram_addr_check.sv | 30 +++
 rtl/apb_ram_slave.sv | 152 +++++++++++++++
 tb/tb_apb_ram_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ram_pkg.sv
// Shared types and response codes for the APB front end of the dual-port word RAM.
package apb_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_DATA,
    ST_ERR
  } apb_ram_state_t;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

endpackage

// File: rtl/apb_ram_addr_check.sv
// Combinational byte-address decode: alignment, range and read-strobe checks plus word index.
module apb_ram_addr_check #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
  parameter int unsigned BYTE_LANE      = 4
) (
  input  logic [APB_ADDR_WIDTH-1:0] addr,
  input  logic                      write,
  input  logic [BYTE_LANE-1:0]      strb,
  output logic                      err,
  output logic [ADDR_WIDTH-1:0]     index
);

  // One extra bit so the byte limit can never wrap in the compare.
  localparam int unsigned LIMIT_W = APB_ADDR_WIDTH + 1;
  localparam logic [LIMIT_W-1:0] BYTE_LIMIT = LIMIT_W'(DEPTH * 4);

  logic misaligned;
  logic out_of_range;
  logic bad_read_strb;

  assign misaligned    = |addr[1:0];
  assign out_of_range  = {1'b0, addr} >= BYTE_LIMIT;
  assign bad_read_strb = !write && (|strb);

  assign err   = misaligned || out_of_range || bad_read_strb;
  assign index = addr[ADDR_WIDTH+1:2];

endmodule

// File: rtl/apb_ram_slave.sv
// APB4 slave front end driving the write port (A) and gated read port (B) of a word RAM.
module apb_ram_slave
  import apb_ram_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
  parameter int unsigned BYTE_LANE      = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [BYTE_LANE-1:0]      pstrb,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  output logic                      write_a,
  output logic [ADDR_WIDTH-1:0]     addr_a,
  output logic [BYTE_LANE-1:0]      byte_sel,
  output logic [DATA_WIDTH-1:0]     datain_a,
  output logic                      read_b,
  output logic [ADDR_WIDTH-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0]     dataout_b
);

  apb_ram_state_t state;
  apb_ram_state_t state_next;

  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic                      pwrite_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic [BYTE_LANE-1:0]      pstrb_q;

  logic                      setup;
  logic                      in_idle;
  logic [APB_ADDR_WIDTH-1:0] chk_addr;
  logic                      chk_write;
  logic [BYTE_LANE-1:0]      chk_strb;
  logic                      chk_err;
  logic [ADDR_WIDTH-1:0]     word_index;

  assign setup   = psel && !penable;
  assign in_idle = (state == ST_IDLE);

  // In IDLE the checker sees the values about to be latched; afterwards it sees the latched copy.
  assign chk_addr  = in_idle ? paddr  : paddr_q;
  assign chk_write = in_idle ? pwrite : pwrite_q;
  assign chk_strb  = in_idle ? pstrb  : pstrb_q;

  apb_ram_addr_check #(
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .BYTE_LANE      (BYTE_LANE)
  ) u_addr_check (
    .addr  (chk_addr),
    .write (chk_write),
    .strb  (chk_strb),
    .err   (chk_err),
    .index (word_index)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Setup-phase capture of the transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (in_idle && setup) begin
      paddr_q  <= paddr;
      pwrite_q <= pwrite;
      pwdata_q <= pwdata;
      pstrb_q  <= pstrb;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (setup) begin
          if (chk_err) begin
            state_next = ST_ERR;
          end else if (pwrite) begin
            state_next = ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_WR:      state_next = ST_IDLE;
      ST_RD:      state_next = psel ? ST_RD_DATA : ST_IDLE;
      ST_RD_DATA: state_next = ST_IDLE;
      ST_ERR:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output decode; RAM strobes are kept mutually exclusive by construction.
  always_comb begin
    pready   = 1'b0;
    pslverr  = APB_OKAY;
    prdata   = '0;
    write_a  = 1'b0;
    addr_a   = '0;
    byte_sel = '0;
    datain_a = '0;
    read_b   = 1'b0;
    addr_b   = '0;
    unique case (state)
      ST_WR: begin
        pready   = 1'b1;
        write_a  = psel && !reset;
        addr_a   = word_index;
        byte_sel = pstrb_q;
        datain_a = pwdata_q;
      end
      ST_RD: begin
        read_b = 1'b1;
        addr_b = word_index;
      end
      ST_RD_DATA: begin
        read_b = 1'b1;
        addr_b = word_index;
        prdata = dataout_b;
        pready = 1'b1;
      end
      ST_ERR: begin
        pready  = 1'b1;
        pslverr = APB_SLVERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// Bench for apb_ram_slave: directed and random APB transfers against a word-level memory model.
module tb_apb_ram_slave;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          psel, penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr, write_a, read_b;
  logic [31:0]   prdata, datain_a, dataout_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [3:0]    byte_sel;

  int vectors     = 0;
  int miscompares = 0;

  apb_ram_slave dut (
    .clk       (clk),
    .reset     (reset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr),
    .write_a   (write_a),
    .addr_a    (addr_a),
    .byte_sel  (byte_sel),
    .datain_a  (datain_a),
    .read_b    (read_b),
    .addr_b    (addr_b),
    .dataout_b (dataout_b)
  );

  always #5 clk = ~clk;

  // Environment RAM: byte-enabled write, registered read gated by read_b && !write_a.
  bit [31:0] ram [DEPTH];
  bit [31:0] ram_q;
  assign dataout_b = ram_q;

  always @(posedge clk) begin
    if (write_a)
      for (int b = 0; b < 4; b++)
        if (byte_sel[b]) ram[addr_a][8*b +: 8] <= datain_a[8*b +: 8];
    ram_q <= (read_b && !write_a) ? ram[addr_b] : 32'h0;
  end

  // Strobe activity monitor.
  int nwr = 0;
  int nrd = 0;
  bit both_seen = 1'b0;
  always @(negedge clk) begin
    if (write_a === 1'b1) nwr++;
    if (read_b === 1'b1) nrd++;
    if (write_a === 1'b1 && read_b === 1'b1) both_seen = 1'b1;
  end

  // Reference model: expected word contents.
  bit [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 32'({pready, pslverr, write_a, read_b}), 32'h0);
    check({tag, "_prdata"}, prdata, 32'h0);
    check({tag, "_addr"}, 32'({addr_a, addr_b, byte_sel}), 32'h0);
    check({tag, "_datain"}, datain_a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
    end
  endtask

  // One complete APB transfer; the next call's setup lands in the cycle right after completion.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input string tag, output logic [31:0] rdata);
    logic        err_e;
    int          idx;
    logic [31:0] exp_rd;
    int          waits, wr0, rd0;
    err_e  = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4)) || (!wr && strb != 4'h0);
    idx    = int'(addr[AW+1:2]);
    exp_rd = (!wr && !err_e) ? ref_mem[idx] : 32'h0;

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    wr0 = nwr; rd0 = nrd;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (pready !== 1'b1 && waits < 6) begin
      waits++;
      @(negedge clk);
    end
    #1;
    rdata = prdata;
    check({tag, "_waits"}, 32'(waits), (!wr && !err_e) ? 32'd1 : 32'd0);
    check({tag, "_pslverr"}, 32'(pslverr), 32'(err_e));
    check({tag, "_prdata"}, prdata, exp_rd);
    check({tag, "_nwrite"}, 32'(nwr - wr0), (wr && !err_e) ? 32'd1 : 32'd0);
    check({tag, "_nread"}, 32'(nrd - rd0), (!wr && !err_e) ? 32'd2 : 32'd0);
    if (wr && !err_e)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");

    // Full write then read back.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd_full", rd);
    check("rd_full_const", rd, 32'hDEADBEEF);
    idle(1);

    // Partial write merges bytes 0 and 2.
    xfer(1'b1, 32'h10, 32'h11223344, 4'h5, "wr_part", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd_part", rd);
    check("rd_part_const", rd, 32'hDE22BE44);

    // Error responses leave RAM untouched.
    xfer(1'b0, 32'h13, 32'h0, 4'h0, "rd_misalign", rd);
    xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, "wr_range", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'h1, "rd_strb", rd);
    xfer(1'b1, 32'h14, 32'h0BADF00D, 4'h0, "wr_nostrb", rd);
    xfer(1'b0, 32'h14, 32'h0, 4'h0, "rd_nostrb", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd_after_err", rd);
    check("rd_after_err_const", rd, 32'hDE22BE44);
    check("ram_word4", ram[4], ref_mem[4]);

    // Back-to-back, no idle cycles.
    xfer(1'b1, 32'h0, 32'hA5A5_0001, 4'hF, "b2b_w0", rd);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, "b2b_r0", rd);
    xfer(1'b1, 32'h4, 32'h5A5A_0004, 4'hF, "b2b_w4", rd);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, "b2b_r4", rd);
    check("b2b_r4_const", rd, 32'h5A5A_0004);

    // Reset asserted during RD drops the transfer.
    idle(1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pstrb = 4'h0;
    @(posedge clk); #1;
    penable = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_quiet("rst_in_rd");
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd_after_rst", rd);
    idle(1);

    // psel dropped in WR suppresses the write.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge clk);
    check("abort_wr_write_a", 32'(write_a), 32'h0);
    @(posedge clk); #1;
    penable = 1'b0;
    @(negedge clk);
    check_quiet("abort_wr_next");
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd_after_abort", rd);
    check("rd_after_abort_const", rd, 32'hDE22BE44);

    // Random traffic over a small hot region plus error cases.
    for (int t = 0; t < 60; t++) begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  s;
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5)      a = 32'($urandom_range(0, 15)) * 4;
      else if (kind == 6) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 7) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      else if (kind == 8) a = 32'hFFC;
      else                a = 32'hFFFF_FFFC;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom);
      if (!w && $urandom_range(0, 7) != 0) s = 4'h0;
      xfer(w, a, d, s, "rand", rd);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    check("ram_word_ffc", ram[DEPTH-1], ref_mem[DEPTH-1]);
    check("strobe_overlap", 32'(both_seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
